// File: rtl/klp32_boot_loader.sv
// Boot loader for KLP32V1: unpacks a length-prefixed byte stream into 32-bit little-endian
// instruction-memory writes and holds the core in reset until the whole program is stored.
module klp32_boot_loader #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_reset,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        StHdrLo,
        StHdrHi,
        StData,
        StFlush,
        StDone,
        StError
    } state_e;

    state_e            stateQ, stateD;
    logic [15:0]       countQ, countD;
    logic [15:0]       wordCntQ, wordCntD;
    logic [1:0]        laneQ, laneD;
    logic [23:0]       bufQ, bufD;
    logic              weQ, weD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [31:0]       wdataQ, wdataD;
    logic [15:0]       fullCount;
    logic              accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StHdrLo;
            countQ   <= '0;
            wordCntQ <= '0;
            laneQ    <= '0;
            bufQ     <= '0;
            weQ      <= 1'b0;
            addrQ    <= '0;
            wdataQ   <= '0;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            wordCntQ <= wordCntD;
            laneQ    <= laneD;
            bufQ     <= bufD;
            weQ      <= weD;
            addrQ    <= addrD;
            wdataQ   <= wdataD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        countD    = countQ;
        wordCntD  = wordCntQ;
        laneD     = laneQ;
        bufD      = bufQ;
        weD       = 1'b0;
        addrD     = addrQ;
        wdataD    = wdataQ;
        fullCount = {i_rx_data, countQ[7:0]};
        accept    = i_rx_valid && o_rx_ready;

        case (stateQ)
            StHdrLo: begin
                if (accept) begin
                    countD[7:0] = i_rx_data;
                    stateD      = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    countD[15:8] = i_rx_data;
                    if (fullCount == 16'd0) begin
                        stateD = StDone;
                    end else if ({16'd0, fullCount} > IMEM_DEPTH) begin
                        stateD = StError;
                    end else begin
                        stateD = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (laneQ == 2'd3) begin
                        weD      = 1'b1;
                        addrD    = wordCntQ[ADDR_W-1:0];
                        wdataD   = {i_rx_data, bufQ};
                        wordCntD = wordCntQ + 16'd1;
                        laneD    = 2'd0;
                        // Last word: the strobe still fires next cycle while input is closed.
                        if (wordCntQ == countQ - 16'd1) begin
                            stateD = StFlush;
                        end
                    end else begin
                        laneD = laneQ + 2'd1;
                        case (laneQ)
                            2'd0:    bufD[7:0]   = i_rx_data;
                            2'd1:    bufD[15:8]  = i_rx_data;
                            default: bufD[23:16] = i_rx_data;
                        endcase
                    end
                end
            end
            StFlush: stateD = StDone;
            default: stateD = stateQ;
        endcase
    end

    assign o_rx_ready   = (stateQ == StHdrLo) || (stateQ == StHdrHi) || (stateQ == StData);
    assign o_imem_we    = weQ;
    assign o_imem_addr  = addrQ;
    assign o_imem_wdata = wdataQ;
    assign o_core_reset = (stateQ != StDone);
    assign o_done       = (stateQ == StDone);
    assign o_error      = (stateQ == StError);

endmodule

// File: tb/tb_klp32_boot_loader.sv
// Directed bench for klp32_boot_loader: streams small programs and checks writes and handshake.
module tb_klp32_boot_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        o_imem_we;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_core_reset;
    logic        o_done;
    logic        o_error;

    int nChecks = 0;
    int nErrors = 0;
    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    logic [7:0]  prog[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h07, 8'h40, 8'h00};

    klp32_boot_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_core_reset (o_core_reset),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && o_imem_we) begin
            logAddr.push_back({24'd0, o_imem_addr});
            logData.push_back(o_imem_wdata);
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        logAddr.delete();
        logData.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tries      = 0;
        while (!o_rx_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries == 20) begin
            nChecks++;
            nErrors++;
            $display("FAIL sendTimeout: byte %h not accepted within 20 cycles", b);
        end
        @(posedge clk);
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic checkProgWrites(input string tag);
        checkVal({tag, "_nWrites"}, logAddr.size(), 2);
        if (logAddr.size() == 2) begin
            checkVal({tag, "_addr0"}, logAddr[0], 32'd0);
            checkVal({tag, "_data0"}, logData[0], 32'h00500513);
            checkVal({tag, "_addr1"}, logAddr[1], 32'd1);
            checkVal({tag, "_data1"}, logData[1], 32'h00400793);
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;

        // 1: idle after reset
        doReset();
        repeat (10) @(negedge clk);
        checkVal("idle_coreReset", o_core_reset, 1);
        checkVal("idle_rxReady", o_rx_ready, 1);
        checkVal("idle_we", o_imem_we, 0);
        checkVal("idle_done", o_done, 0);
        checkVal("idle_error", o_error, 0);
        checkVal("idle_addr", o_imem_addr, 0);
        checkVal("idle_wdata", o_imem_wdata, 0);

        // 2: back-to-back stream
        for (int i = 0; i < 10; i++) sendByte(prog[i], 0);
        checkVal("t2_flushWe", o_imem_we, 1);
        checkVal("t2_flushReady", o_rx_ready, 0);
        checkVal("t2_flushDone", o_done, 0);
        checkVal("t2_flushCoreReset", o_core_reset, 1);
        @(negedge clk);
        checkVal("t2_done", o_done, 1);
        checkVal("t2_coreReset", o_core_reset, 0);
        checkVal("t2_weLow", o_imem_we, 0);
        checkVal("t2_holdAddr", o_imem_addr, 1);
        checkVal("t2_holdData", o_imem_wdata, 32'h00400793);
        repeat (3) @(negedge clk);
        checkVal("t2_readyAfter", o_rx_ready, 0);
        checkProgWrites("t2");

        // 3: same stream with 3 idle cycles between bytes
        doReset();
        for (int i = 0; i < 10; i++) sendByte(prog[i], 3);
        @(negedge clk);
        checkVal("t3_done", o_done, 1);
        checkVal("t3_coreReset", o_core_reset, 0);
        checkProgWrites("t3");

        // 4: empty program
        doReset();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        checkVal("t4_done", o_done, 1);
        checkVal("t4_coreReset", o_core_reset, 0);
        checkVal("t4_ready", o_rx_ready, 0);
        i_rx_data  = 8'hAA;
        i_rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        i_rx_valid = 1'b0;
        checkVal("t4_readyStill", o_rx_ready, 0);
        checkVal("t4_nWrites", logAddr.size(), 0);

        // 5: oversize count 257
        doReset();
        sendByte(8'h01, 0);
        sendByte(8'h01, 0);
        checkVal("t5_error", o_error, 1);
        checkVal("t5_coreReset", o_core_reset, 1);
        checkVal("t5_ready", o_rx_ready, 0);
        checkVal("t5_done", o_done, 0);
        repeat (5) @(negedge clk);
        checkVal("t5_nWrites", logAddr.size(), 0);

        // 6: abort mid-load with reset, then reload
        doReset();
        for (int i = 0; i < 7; i++) sendByte(prog[i], 0);
        #2 reset = 1'b1;
        #1;
        checkVal("t6_asyncReady", o_rx_ready, 1);
        checkVal("t6_asyncCoreReset", o_core_reset, 1);
        checkVal("t6_asyncWe", o_imem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        logAddr.delete();
        logData.delete();
        for (int i = 0; i < 10; i++) sendByte(prog[i], 0);
        @(negedge clk);
        checkVal("t6_done", o_done, 1);
        checkProgWrites("t6");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL globalTimeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
